// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and field widths for the 16-bit processor control.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam int unsigned INSTR_W   = 16;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned REG_W     = 4;
    localparam int unsigned D_ADDR_W  = 8;
    localparam int unsigned ALU_SEL_W = 3;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_STORE  = 4'd4,
        S_LOAD_A = 4'd5,
        S_LOAD_B = 4'd6,
        S_ALU_OP = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5,
        OP_XOR   = 4'h6,
        OP_OR    = 4'h7,
        OP_AND   = 4'h8,
        OP_MOV   = 4'h9,
        OP_INC   = 4'hA
    } opcode_t;

    typedef logic [ALU_SEL_W-1:0] alu_sel_t;

    localparam alu_sel_t ALU_ZERO = 3'd0;
    localparam alu_sel_t ALU_ADD  = 3'd1;
    localparam alu_sel_t ALU_SUB  = 3'd2;
    localparam alu_sel_t ALU_PASS = 3'd3;
    localparam alu_sel_t ALU_XOR  = 3'd4;
    localparam alu_sel_t ALU_OR   = 3'd5;
    localparam alu_sel_t ALU_AND  = 3'd6;
    localparam alu_sel_t ALU_INC  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/alu_sel_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_sel_decode
// Description : Opcode to ALU function select, with ALU-class and illegal flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sel_decode
    import proc_pkg::*;
(
    input  opcode_t  i_op,
    output alu_sel_t o_alu_sel,
    output logic     o_is_alu_op,
    output logic     o_is_illegal
);

    always_comb begin
        o_alu_sel   = ALU_ZERO;
        o_is_alu_op = 1'b1;
        case (i_op)
            OP_ADD:  o_alu_sel = ALU_ADD;
            OP_SUB:  o_alu_sel = ALU_SUB;
            OP_XOR:  o_alu_sel = ALU_XOR;
            OP_OR:   o_alu_sel = ALU_OR;
            OP_AND:  o_alu_sel = ALU_AND;
            OP_MOV:  o_alu_sel = ALU_PASS;
            OP_INC:  o_alu_sel = ALU_INC;
            default: o_is_alu_op = 1'b0;
        endcase
    end

    // Opcodes above INC have no defined behaviour
    assign o_is_illegal = (i_op > OP_INC);

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Multi-cycle fetch/decode/execute control FSM for the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import proc_pkg::*;
(
    input  logic        Clk,
    input  logic        ResetN,
    input  logic [15:0] IR,
    output logic        PC_clr,
    output logic        PC_up,
    output logic        IR_ld,
    output logic [7:0]  D_addr,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s,
    output logic        Halt,
    output logic        Illegal,
    output logic [15:0] InstrCount,
    output logic [3:0]  CurState
);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_count;
    logic        r_illegal;
    opcode_t     w_op;
    alu_sel_t    w_alu_sel;
    logic        w_is_alu_op;
    logic        w_is_illegal;
    logic        w_retire;

    assign w_op = opcode_t'(IR[15:12]);

    alu_sel_decode u_alu_sel_decode (
        .i_op         (w_op),
        .o_alu_sel    (w_alu_sel),
        .o_is_alu_op  (w_is_alu_op),
        .o_is_illegal (w_is_illegal)
    );

    assign w_retire = (r_state == S_NOOP)  || (r_state == S_STORE) ||
                      (r_state == S_LOAD_B) || (r_state == S_ALU_OP);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_state       <= S_INIT;
            r_instr_count <= 16'd0;
            r_illegal     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
            if ((r_state == S_DECODE) && w_is_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = 8'd0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = 4'd0;
        RF_Rb_addr = 4'd0;
        ALU_s      = ALU_ZERO;
        Halt       = 1'b0;
        case (r_state)
            S_INIT: begin
                PC_clr = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                IR_ld  = 1'b1;
                PC_up  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                // Illegal opcodes fall through to NOOP so they still retire
                if (w_op == OP_STORE) begin
                    w_next = S_STORE;
                end else if (w_op == OP_LOAD) begin
                    w_next = S_LOAD_A;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else if (w_is_alu_op) begin
                    w_next = S_ALU_OP;
                end else begin
                    w_next = S_NOOP;
                end
            end
            S_NOOP: begin
                w_next = S_FETCH;
            end
            S_STORE: begin
                D_addr     = IR[7:0];
                RF_Ra_addr = IR[11:8];
                D_wr       = 1'b1;
                w_next     = S_FETCH;
            end
            S_LOAD_A: begin
                D_addr = IR[11:4];
                w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_addr    = IR[11:4];
                RF_s      = 1'b1;
                RF_W_addr = IR[3:0];
                RF_W_en   = 1'b1;
                w_next    = S_FETCH;
            end
            S_ALU_OP: begin
                RF_Ra_addr = IR[11:8];
                RF_Rb_addr = IR[7:4];
                RF_W_addr  = IR[3:0];
                RF_W_en    = 1'b1;
                ALU_s      = w_alu_sel;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                Halt   = 1'b1;
                w_next = S_HALT;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    assign Illegal    = r_illegal;
    assign InstrCount = r_instr_count;
    assign CurState   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_control_unit
// Description : Randomized scoreboard bench for control_unit against an
//               instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;
    import proc_pkg::*;

    logic        Clk = 1'b0;
    logic        ResetN = 1'b0;
    logic [15:0] IR = 16'd0;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halt, Illegal;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, CurState;
    logic [2:0]  ALU_s;
    logic [15:0] InstrCount;

    control_unit dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s      (ALU_s),
        .Halt       (Halt),
        .Illegal    (Illegal),
        .InstrCount (InstrCount),
        .CurState   (CurState)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  st;
        logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en, halt, ill;
        logic [7:0]  d_addr;
        logic [3:0]  w_addr, ra, rb;
        logic [2:0]  alu;
        logic [15:0] cnt;
    } exp_t;

    localparam int K_NOOP  = 0;
    localparam int K_STORE = 1;
    localparam int K_LOAD  = 2;
    localparam int K_ALU   = 3;
    localparam int K_HALT  = 4;

    exp_t        sb[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_ill = 1'b0;

    function automatic int kind_of(input logic [3:0] op);
        case (op)
            4'h0:                             return K_NOOP;
            4'h1:                             return K_STORE;
            4'h2:                             return K_LOAD;
            4'h5:                             return K_HALT;
            4'h3, 4'h4, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hA:                       return K_ALU;
            default:                          return K_NOOP;
        endcase
    endfunction

    // Function codes: 1 add, 2 sub, 3 pass A, 4 xor, 5 or, 6 and, 7 A+1
    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'h3:    return 3'd1;
            4'h4:    return 3'd2;
            4'h6:    return 3'd4;
            4'h7:    return 3'd5;
            4'h8:    return 3'd6;
            4'h9:    return 3'd3;
            4'hA:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic exp_t blank(input state_t s);
        exp_t e;
        e.st = s;      e.pc_clr = 1'b0; e.pc_up = 1'b0; e.ir_ld = 1'b0;
        e.d_wr = 1'b0; e.rf_s = 1'b0;   e.w_en = 1'b0;  e.halt = 1'b0;
        e.d_addr = 8'd0; e.w_addr = 4'd0; e.ra = 4'd0; e.rb = 4'd0;
        e.alu = 3'd0;  e.ill = m_ill;   e.cnt = m_cnt;
        return e;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("CurState",   16'(CurState),   16'(cur.st));
            chk("PC_clr",     16'(PC_clr),     16'(cur.pc_clr));
            chk("PC_up",      16'(PC_up),      16'(cur.pc_up));
            chk("IR_ld",      16'(IR_ld),      16'(cur.ir_ld));
            chk("D_addr",     16'(D_addr),     16'(cur.d_addr));
            chk("D_wr",       16'(D_wr),       16'(cur.d_wr));
            chk("RF_s",       16'(RF_s),       16'(cur.rf_s));
            chk("RF_W_addr",  16'(RF_W_addr),  16'(cur.w_addr));
            chk("RF_W_en",    16'(RF_W_en),    16'(cur.w_en));
            chk("RF_Ra_addr", 16'(RF_Ra_addr), 16'(cur.ra));
            chk("RF_Rb_addr", 16'(RF_Rb_addr), 16'(cur.rb));
            chk("ALU_s",      16'(ALU_s),      16'(cur.alu));
            chk("Halt",       16'(Halt),       16'(cur.halt));
            chk("Illegal",    16'(Illegal),    16'(cur.ill));
            chk("InstrCount", InstrCount,      cur.cnt);
        end
    end

    // Called with ResetN already low and the DUT already in INIT
    task automatic post_reset(input int hold);
        exp_t e;
        for (int j = 0; j < hold; j++) begin
            m_cnt = 16'd0;
            m_ill = 1'b0;
            if (j == hold - 1) ResetN = 1'b1;
            e = blank(S_INIT);
            e.pc_clr = 1'b1;
            sb.push_back(e);
            @(posedge Clk); #1;
        end
    endtask

    task automatic run_instr(input logic [15:0] ir, input int abort_in, input bit preload);
        exp_t       seq[$];
        exp_t       e;
        int         k;
        int         abort_at;
        bit         aborted;
        logic [3:0] op;
        op       = ir[15:12];
        k        = kind_of(op);
        abort_at = abort_in;
        aborted  = 1'b0;
        if (preload) begin
            force dut.r_instr_count = 16'hFFFF;
            m_cnt = 16'hFFFF;
        end
        e = blank(S_FETCH); e.pc_up = 1'b1; e.ir_ld = 1'b1;
        seq.push_back(e);
        seq.push_back(blank(S_DECODE));
        if (op >= 4'hB) m_ill = 1'b1;
        case (k)
            K_STORE: begin
                e = blank(S_STORE); e.d_addr = ir[7:0]; e.ra = ir[11:8]; e.d_wr = 1'b1;
                seq.push_back(e);
            end
            K_LOAD: begin
                e = blank(S_LOAD_A); e.d_addr = ir[11:4];
                seq.push_back(e);
                e.st = S_LOAD_B; e.rf_s = 1'b1; e.w_addr = ir[3:0]; e.w_en = 1'b1;
                seq.push_back(e);
            end
            K_ALU: begin
                e = blank(S_ALU_OP); e.ra = ir[11:8]; e.rb = ir[7:4];
                e.w_addr = ir[3:0]; e.w_en = 1'b1; e.alu = alu_of(op);
                seq.push_back(e);
            end
            K_HALT: begin
                repeat (4) begin
                    e = blank(S_HALT); e.halt = 1'b1;
                    seq.push_back(e);
                end
            end
            default: seq.push_back(blank(S_NOOP));
        endcase
        // HALT is only left through reset
        if (k == K_HALT) abort_at = seq.size() - 1;
        for (int i = 0; i < seq.size(); i++) begin
            if (i == 1) IR = ir;
            if (i == abort_at) ResetN = 1'b0;
            sb.push_back(seq[i]);
            if (preload && i == 1) release dut.r_instr_count;
            @(posedge Clk); #1;
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) post_reset(int'($urandom_range(1, 2)));
        else         m_cnt = m_cnt + 16'd1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rir;
        int          ab;
        bit          pl;
        ResetN = 1'b0;
        @(posedge Clk); #1;
        post_reset(3);

        run_instr(16'h3125, -1, 1'b0);
        run_instr(16'h21A4, -1, 1'b0);
        run_instr(16'h17C3, -1, 1'b0);
        run_instr(16'h6123, -1, 1'b0);
        run_instr(16'h7456, -1, 1'b0);
        run_instr(16'h889A, -1, 1'b0);
        run_instr(16'h9BC0, -1, 1'b0);
        run_instr(16'hAD0E, -1, 1'b0);
        run_instr(16'hF000, -1, 1'b0);
        run_instr(16'h0000, -1, 1'b0);
        run_instr(16'h21A4, 3, 1'b0);
        run_instr(16'h4321, -1, 1'b1);
        run_instr(16'h0000, -1, 1'b0);
        run_instr(16'h5000, -1, 1'b0);

        for (int n = 0; n < 200; n++) begin
            rir = 16'($urandom);
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            pl  = ($urandom_range(0, 19) == 0) && (ab < 0) && (rir[15:12] != 4'h5);
            run_instr(rir, ab, pl);
        end

        repeat (2) @(posedge Clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 16-bit programmable processor: the driving end of the ALU's select/operand interface. Sequences fetch, decode and execute for each instruction word. Produces the program-counter, instruction-register, data-memory, register-file and ALU-select controls that the datapath consumes.

## Interface
- Parameters: none. All widths are fixed by `proc_pkg`.
- `Clk`  in  1  single system clock; all state changes on the rising edge.
- `ResetN`  in  1  synchronous, active-low reset.
- `IR`  in  16  current instruction from the external IR.
  - Stable except on the edge that ends FETCH.
- `PC_clr`  out  1  clear the PC.
- `PC_up`  out  1  increment the PC.
- `IR_ld`  out  1  load the IR from instruction memory.
- `D_addr`  out  8  data-memory address.
- `D_wr`  out  1  data-memory write enable.
- `RF_s`  out  1  register-file write-data mux select: 1 = data memory, 0 = ALU.
- `RF_W_addr`  out  4  register-file write address.
- `RF_W_en`  out  1  register-file write enable.
- `RF_Ra_addr`, `RF_Rb_addr`  out  4 each  register-file read ports A and B.
- `ALU_s`  out  3  ALU function select.
  - 0 zero, 1 add, 2 sub, 3 pass A, 4 xor, 5 or, 6 and, 7 A+1.
- `Halt`  out  1  high while in HALT.
- `Illegal`  out  1  sticky: an undefined opcode was decoded since reset.
- `InstrCount`  out  16  count of retired instructions.
- `CurState`  out  4  state encoding, for debug.

## Operation
- Instruction fields:
  - `op` = IR[15:12].
  - ALU format: Ra = IR[11:8], Rb = IR[7:4], Rw = IR[3:0].
  - STORE: Ra = IR[11:8], address = IR[7:0].
  - LOAD: address = IR[11:4], Rw = IR[3:0].
- Opcodes:
  - 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT.
  - 6 XOR, 7 OR, 8 AND, 9 MOV (pass A), A INC (Ra+1).
  - B–F illegal: executed as NOOP, set `Illegal`.
- States:
  - INIT: `PC_clr`=1, `InstrCount` cleared.
  - FETCH: `IR_ld`=1, `PC_up`=1.
  - DECODE: no enables.
  - NOOP: no enables.
  - STORE: `D_addr`=IR[7:0], `RF_Ra_addr`=IR[11:8], `D_wr`=1.
  - LOAD_A: `D_addr`=IR[11:4]; covers synchronous memory read latency.
  - LOAD_B: same `D_addr`, `RF_s`=1, `RF_W_addr`=IR[3:0], `RF_W_en`=1.
  - ALU_OP: Ra/Rb/Rw from IR, `RF_s`=0, `RF_W_en`=1, `ALU_s` from opcode.
  - HALT: `Halt`=1.
- Transitions:
  - INIT→FETCH→DECODE.
  - DECODE→{NOOP | STORE | LOAD_A | ALU_OP | HALT} by `op`.
  - LOAD_A→LOAD_B.
  - NOOP/STORE/LOAD_B/ALU_OP→FETCH.
  - HALT→HALT until reset.
- Output rules:
  - Every output not listed for a state is 0, including `ALU_s`=0.
  - Outputs are combinational from the state register and `IR` (Moore plus IR fields).
- `InstrCount`:
  - Increments by 1 on the edge leaving NOOP, STORE, LOAD_B or ALU_OP.
  - Wraps 0xFFFF→0x0000.
  - An illegal opcode counts as retired.
  - HALT is not counted.

## Timing
- Reset:
  - ResetN low at a rising edge forces state INIT, `InstrCount`=0, `Illegal`=0.
  - This holds from any state, including mid-LOAD and HALT.
  - Cycle after reset: `PC_clr`=1; every other output 0; `CurState`=INIT.
  - ResetN held low keeps the block in INIT.
- Cycles per instruction, FETCH to next FETCH:
  - NOOP/STORE/ALU: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: reached 2 cycles after FETCH.
- Write enables (`D_wr`, `RF_W_en`) are asserted for exactly one cycle per instruction.
- The first FETCH occurs on the cycle after INIT.

## Structure
- `proc_pkg` holds:
  - the `state_t` enum, 4-bit;
  - the `opcode_t` enum;
  - `alu_sel_t` constants ALU_ZERO … ALU_INC (0–7);
  - the field-slice widths.
- Sub-module `alu_sel_decode`: combinational map `opcode_t` → (`alu_sel_t`, `is_alu_op`, `is_illegal`). Used by both DECODE and ALU_OP.
- The top holds the state register, next-state logic, output decode, the counter and the sticky flag.

## Test plan
- Reset, then release: INIT for one cycle with `PC_clr`=1, then FETCH with `IR_ld`=`PC_up`=1; `InstrCount`=0.
- IR=16'h3125 (ADD R1,R2→R5): in ALU_OP, `ALU_s`=1, Ra=1, Rb=2, `RF_W_addr`=5, `RF_W_en`=1, `RF_s`=0; `InstrCount` +1; 3 cycles FETCH→FETCH.
- IR=16'h21A4 (LOAD D[0x1A]→R4): LOAD_A drives `D_addr`=0x1A with no enables; LOAD_B drives `RF_s`=1, `RF_W_addr`=4, `RF_W_en`=1; 4-cycle CPI.
- IR=16'h17C3 (STORE R7→D[0xC3]): `D_wr`=1 for one cycle, `D_addr`=0xC3, `RF_Ra_addr`=7. Opcodes 6–A yield `ALU_s` 4,5,6,3,7 respectively.
- IR=16'hF000: behaves as NOOP, `Illegal` goes and stays 1. IR=16'h5000: enters HALT, `Halt`=1 indefinitely, `InstrCount` frozen.
- ResetN low during LOAD_B and during HALT: next cycle INIT, `RF_W_en`=0, `Illegal`=0, `InstrCount`=0. Preloading the counter at 0xFFFF and retiring one instruction gives 0x0000.
